// File: rtl/regfile_pkg.sv
// Shared constants, state/grant encodings and writeback payload type for the
// register file writeback path.
package regfile_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32'(1) << REG_AW;

    typedef enum logic {
        WB_INIT,
        WB_RUN
    } wb_state_t;

    typedef enum logic {
        GNT_ALU,
        GNT_LSU
    } wb_gnt_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd_src;
        logic [XLEN-1:0]   rd;
    } wb_req_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way combinational writeback grant. WB_ROUND_ROBIN_EN selects alternating
// priority on contention; otherwise LSU has fixed priority over ALU.
module wb_rr_arbiter
    import regfile_pkg::*;
(
    input  logic    alu_valid,
    input  logic    lsu_valid,
    input  wb_gnt_t last_grant,
    output logic    gnt_alu_c,
    output logic    gnt_lsu_c
);

`ifndef WB_ROUND_ROBIN_EN
    // Fixed priority ignores history; keep the port so both builds share one interface.
    logic last_grant_unused;
    assign last_grant_unused = last_grant;
`endif

    always_comb begin
        gnt_alu_c = 1'b0;
        gnt_lsu_c = 1'b0;
        if (alu_valid && lsu_valid) begin
`ifdef WB_ROUND_ROBIN_EN
            if (last_grant == GNT_LSU) begin
                gnt_alu_c = 1'b1;
            end else begin
                gnt_lsu_c = 1'b1;
            end
`else
            gnt_lsu_c = 1'b1;
`endif
        end else begin
            gnt_alu_c = alu_valid;
            gnt_lsu_c = lsu_valid;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write port owner: zero-fill sweep after reset, then ALU/LSU
// writeback arbitration with registered write outputs. Policy via WB_ROUND_ROBIN_EN.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd_src,
    input  logic [XLEN-1:0]   alu_rd,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd_src,
    input  logic [XLEN-1:0]   lsu_rd,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_src,
    output logic [XLEN-1:0]   wr_data,
    output logic              init_done
);

    wb_state_t         state_q, state_d;
    logic [REG_AW-1:0] cnt_q, cnt_d;
    wb_gnt_t           last_grant_q, last_grant_d;
    logic              wr_en_q, wr_en_d;
    logic [REG_AW-1:0] wr_src_q, wr_src_d;
    logic [XLEN-1:0]   wr_data_q, wr_data_d;
    logic              init_done_q, init_done_d;

    logic              gnt_alu_c, gnt_lsu_c;
    wb_req_t           win_c;

    wb_rr_arbiter u_arb (
        .alu_valid  (alu_valid),
        .lsu_valid  (lsu_valid),
        .last_grant (last_grant_q),
        .gnt_alu_c  (gnt_alu_c),
        .gnt_lsu_c  (gnt_lsu_c)
    );

    // Next-state, sweep counter, grant bookkeeping and write-port loads.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        wr_src_d     = wr_src_q;
        wr_data_d    = wr_data_q;
        init_done_d  = init_done_q;
        alu_ready    = 1'b0;
        lsu_ready    = 1'b0;
        win_c        = '{rd_src: alu_rd_src, rd: alu_rd};

        case (state_q)
            WB_INIT: begin
                wr_en_d   = 1'b1;
                wr_src_d  = cnt_q;
                wr_data_d = '0;
                cnt_d     = cnt_q + REG_AW'(1);
                if (cnt_q == REG_AW'(NUM_REGS - 1)) begin
                    state_d     = WB_RUN;
                    init_done_d = 1'b1;
                end
            end
            WB_RUN: begin
                alu_ready = gnt_alu_c;
                lsu_ready = gnt_lsu_c;
                if (gnt_lsu_c) begin
                    win_c        = '{rd_src: lsu_rd_src, rd: lsu_rd};
                    last_grant_d = GNT_LSU;
                end else if (gnt_alu_c) begin
                    last_grant_d = GNT_ALU;
                end
                // x0 is hardwired zero: accept the handshake but never write it.
                if ((gnt_alu_c || gnt_lsu_c) && (win_c.rd_src != '0)) begin
                    wr_en_d   = 1'b1;
                    wr_src_d  = win_c.rd_src;
                    wr_data_d = win_c.rd;
                end
            end
            default: begin
                state_d = WB_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WB_INIT;
            cnt_q        <= '0;
            last_grant_q <= GNT_ALU;
            wr_en_q      <= 1'b0;
            wr_src_q     <= '0;
            wr_data_q    <= '0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_src_q     <= wr_src_d;
            wr_data_q    <= wr_data_d;
            init_done_q  <= init_done_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_src    = wr_src_q;
    assign wr_data   = wr_data_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; expectations for the
// contended cases follow WB_ROUND_ROBIN_EN when it is defined.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd_src;
    logic [31:0] alu_rd;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd_src;
    logic [31:0] lsu_rd;
    logic        wr_en;
    logic [4:0]  wr_src;
    logic [31:0] wr_data;
    logic        init_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd_src (alu_rd_src),
        .alu_rd     (alu_rd),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd_src (lsu_rd_src),
        .lsu_rd     (lsu_rd),
        .wr_en      (wr_en),
        .wr_src     (wr_src),
        .wr_data    (wr_data),
        .init_done  (init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Contended-pair and held-ALU orders depend on the configured policy.
`ifdef WB_ROUND_ROBIN_EN
    logic [4:0]  pair_src [2] = '{5'd12, 5'd13};
    logic [31:0] pair_dat [2] = '{32'h0000_000C, 32'h0000_000D};
    logic [4:0]  t6_src   [3] = '{5'd9, 5'd10, 5'd11};
    logic [31:0] t6_dat   [3] = '{32'h0000_AAAA, 32'h0000_00B1, 32'h0000_00B2};
`else
    logic [4:0]  pair_src [2] = '{5'd13, 5'd12};
    logic [31:0] pair_dat [2] = '{32'h0000_000D, 32'h0000_000C};
    logic [4:0]  t6_src   [3] = '{5'd10, 5'd11, 5'd9};
    logic [31:0] t6_dat   [3] = '{32'h0000_00B1, 32'h0000_00B2, 32'h0000_AAAA};
`endif

    initial begin
        int alu_acc;
        int lsu_n;
        logic a_rdy, l_rdy;

        rst = 1'b0;
        alu_valid = 1'b1; alu_rd_src = 5'd0; alu_rd = 32'h0000_1234;
        lsu_valid = 1'b0; lsu_rd_src = 5'd0; lsu_rd = 32'h0;
        tick();
        tick();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_src", 32'(wr_src), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Sweep: 32 zero writes; ALU (x0) held valid must not see ready until RUN.
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("sweep_wr_en", 32'(wr_en), 32'd1);
            chk("sweep_wr_src", 32'(wr_src), 32'(i));
            chk("sweep_wr_data", wr_data, 32'd0);
            chk("sweep_init_done", 32'(init_done), (i == 31) ? 32'd1 : 32'd0);
            chk("sweep_alu_ready", 32'(alu_ready), (i == 31) ? 32'd1 : 32'd0);
        end
        tick();
        alu_valid = 1'b0;
        chk("x0_alu_wr_en", 32'(wr_en), 32'd0);

        // Single ALU request.
        alu_valid = 1'b1; alu_rd_src = 5'd5; alu_rd = 32'hDEAD_BEEF;
        #1;
        chk("t2_alu_ready", 32'(alu_ready), 32'd1);
        chk("t2_lsu_ready", 32'(lsu_ready), 32'd0);
        tick();
        alu_valid = 1'b0;
        chk("t2_wr_en", 32'(wr_en), 32'd1);
        chk("t2_wr_src", 32'(wr_src), 32'd5);
        chk("t2_wr_data", wr_data, 32'hDEAD_BEEF);
        tick();
        chk("t2_idle_wr_en", 32'(wr_en), 32'd0);
        chk("t2_hold_wr_src", 32'(wr_src), 32'd5);
        chk("t2_hold_wr_data", wr_data, 32'hDEAD_BEEF);

        // Contention after an ALU grant: LSU wins under both policies.
        alu_valid = 1'b1; alu_rd_src = 5'd3; alu_rd = 32'd1;
        lsu_valid = 1'b1; lsu_rd_src = 5'd4; lsu_rd = 32'd2;
        #1;
        chk("t3_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("t3_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        lsu_valid = 1'b0;
        chk("t3_first_src", 32'(wr_src), 32'd4);
        chk("t3_first_data", wr_data, 32'd2);
        #1;
        chk("t3_alu_ready2", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("t3_second_en", 32'(wr_en), 32'd1);
        chk("t3_second_src", 32'(wr_src), 32'd3);
        chk("t3_second_data", wr_data, 32'd1);

        // LSU write to x0.
        lsu_valid = 1'b1; lsu_rd_src = 5'd0; lsu_rd = 32'hFFFF_FFFF;
        #1;
        chk("t4_lsu_ready", 32'(lsu_ready), 32'd1);
        tick();
        lsu_valid = 1'b0;
        chk("t4_wr_en", 32'(wr_en), 32'd0);

        // Contended pair after an LSU grant.
        alu_valid = 1'b1; alu_rd_src = 5'd12; alu_rd = 32'h0000_000C;
        lsu_valid = 1'b1; lsu_rd_src = 5'd13; lsu_rd = 32'h0000_000D;
        for (int k = 0; k < 2; k++) begin
            #1;
            a_rdy = alu_ready; l_rdy = lsu_ready;
            tick();
            chk("pair_wr_en", 32'(wr_en), 32'd1);
            chk("pair_wr_src", 32'(wr_src), 32'(pair_src[k]));
            chk("pair_wr_data", wr_data, pair_dat[k]);
            if (a_rdy) alu_valid = 1'b0;
            if (l_rdy) lsu_valid = 1'b0;
        end

        // ALU holds valid while LSU issues two loads; ALU accepted exactly once.
        alu_valid = 1'b1; alu_rd_src = 5'd9; alu_rd = 32'h0000_AAAA;
        lsu_valid = 1'b1; lsu_rd_src = 5'd10; lsu_rd = 32'h0000_00B1;
        alu_acc = 0; lsu_n = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            a_rdy = alu_ready; l_rdy = lsu_ready;
            tick();
            chk("t6_wr_en", 32'(wr_en), 32'd1);
            chk("t6_wr_src", 32'(wr_src), 32'(t6_src[k]));
            chk("t6_wr_data", wr_data, t6_dat[k]);
            if (a_rdy) begin
                alu_acc++;
                alu_valid = 1'b0;
            end
            if (l_rdy) begin
                lsu_n++;
                if (lsu_n == 2) lsu_valid = 1'b0;
                else begin
                    lsu_rd_src = 5'd11; lsu_rd = 32'h0000_00B2;
                end
            end
        end
        chk("t6_alu_accepts", 32'(alu_acc), 32'd1);
        tick();
        chk("t6_idle_wr_en", 32'(wr_en), 32'd0);

        // Reset in RUN, then again mid-sweep at cnt=10.
        rst = 1'b0;
        #1;
        chk("run_rst_init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("pre_rst_wr_src", 32'(wr_src), 32'd9);
        rst = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_wr_src", 32'(wr_src), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("resweep_wr_en", 32'(wr_en), 32'd1);
            chk("resweep_wr_src", 32'(wr_src), 32'(i));
            chk("resweep_init_done", 32'(init_done), (i == 31) ? 32'd1 : 32'd0);
        end

        // Grant history cleared: first contended grant goes to LSU.
        alu_valid = 1'b1; alu_rd_src = 5'd20; alu_rd = 32'h0000_0014;
        lsu_valid = 1'b1; lsu_rd_src = 5'd21; lsu_rd = 32'h0000_0015;
        #1;
        chk("post_rst_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("post_rst_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk("post_rst_wr_src", 32'(wr_src), 32'd21);
        chk("post_rst_wr_data", wr_data, 32'h0000_0015);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
